// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: LDR/STR memory stage driving a 16-bit SRAM as two half-word transfers,
// holding ready low while an access is in flight so the pipeline freezes.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_Rm,
  output logic        ready,
  output logic [31:0] rd_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] idx_q, idx_d, word_idx;
  logic [31:0] data_q, data_d, rd_data_q, rd_data_d;
  logic        last, xfer, lo, hi, wr;
  // Byte offset from the SRAM base, wrapping modulo 2^32; bits [1:0] are dropped.
  assign word_idx = 17'((alu_result - ADDR_BASE) >> 2);
  assign last = cnt_q == 4'(WAIT_CYCLES - 1);
  assign lo   = state_q == RD_LO || state_q == WR_LO;
  assign hi   = state_q == RD_HI || state_q == WR_HI;
  assign wr   = state_q == WR_LO || state_q == WR_HI;
  assign xfer = lo || hi;
  always_comb begin
    state_d   = state_q;
    cnt_d     = (xfer && !last) ? cnt_q + 4'd1 : 4'd0;
    idx_d     = idx_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    if (state_q == IDLE) begin
      if (mem_write) begin
        state_d = WR_LO;
        idx_d   = word_idx;
        data_d  = val_Rm;
      end else if (mem_read) begin
        state_d = RD_LO;
        idx_d   = word_idx;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (last) begin
      state_d = state_q == RD_LO ? RD_HI : state_q == WR_LO ? WR_HI : DONE;
      if (state_q == RD_LO) rd_data_d[15:0] = sram_dq_in;
      if (state_q == RD_HI) rd_data_d[31:16] = sram_dq_in;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign sram_addr   = lo ? {idx_q, 1'b0} : hi ? {idx_q, 1'b1} : '0;
  assign sram_we_n   = !wr;
  assign sram_dq_oe  = wr;
  assign sram_dq_out = state_q == WR_LO ? data_q[15:0] : state_q == WR_HI ? data_q[31:16] : '0;
  assign ready       = (state_q == IDLE && !mem_read && !mem_write) || state_q == DONE;
  assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: vector table plus rd_data scoreboard for the SRAM memory stage.
module tb_mem_stage_sram_ctrl;
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [17:0] exp_a;
    logic [31:0] exp_rd;
  } vec_t;
  logic        clk = 0, rst = 1;
  logic        mem_read = 0, mem_write = 0, ready, sram_dq_oe, sram_we_n;
  logic [31:0] alu_result = 0, val_Rm = 0, rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        rd1 = 0, wr1 = 0, ready1, oe1, we_n1;
  logic [31:0] addr1 = 0, val1 = 0, rd_data1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [31:0] sb [$];
  vec_t        vecs [10];
  int          pass_cnt = 0, total_cnt = 0;
  mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .alu_result(alu_result), .val_Rm(val_Rm), .ready(ready), .rd_data(rd_data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));
  mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
    .alu_result(addr1), .val_Rm(val1), .ready(ready1), .rd_data(rd_data1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1));
  always #5 clk = ~clk;
  assign sram_dq_in = mem0[sram_addr[7:0]];
  assign dq_in1     = mem1[sram_addr1[7:0]];
  always @(posedge clk) if (!sram_we_n) mem0[sram_addr[7:0]] <= sram_dq_out;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else pass_cnt++;
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] e;
    @(negedge clk);
    chk("idle_ready", ready, 1);
    mem_write = v.wr; mem_read = v.rd; alu_result = v.addr; val_Rm = v.data;
    sb.push_back(v.exp_rd);
    #1 chk("req_ready", ready, 0);
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        mem_write = 0; mem_read = 0; alu_result = $urandom; val_Rm = $urandom;
        chk("xfer_ready", ready, 0);
        chk("sram_addr", sram_addr, v.exp_a + 18'(h));
        chk("we_n", sram_we_n, !v.wr);
        chk("dq_oe", sram_dq_oe, v.wr);
        chk("dq_out", sram_dq_out, !v.wr ? 16'h0 : h == 0 ? v.data[15:0] : v.data[31:16]);
      end
    @(negedge clk);
    chk("done_ready", ready, 1);
    chk("done_addr", sram_addr, 0);
    e = sb.pop_front();
    chk("rd_data", rd_data, e);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    mem0[8] = 16'hCAFE; mem0[9] = 16'h1234;
    mem1[6] = 16'h7777; mem1[7] = 16'h8888;
    vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'h1234CAFE};
    vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h12345678, 18'd0, 32'h1234CAFE};
    vecs[4] = '{1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 18'd2, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 18'h3FFFE, 32'hA5A55A5A};
    vecs[8] = '{1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'h0BADF00D};
    vecs[9] = '{1'b0, 1'b1, 32'd1035, 32'h0, 18'd4, 32'hDEADBEEF};
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    rst = 0;
    // Abort a store in WR_LO with an asynchronous reset.
    @(negedge clk);
    mem_write = 1; alu_result = 32'd1100; val_Rm = 32'h11112222;
    @(negedge clk);
    mem_write = 0;
    chk("abort_pre_we_n", sram_we_n, 0);
    chk("abort_pre_addr", sram_addr, 18'd38);
    #1 rst = 1;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe", sram_dq_oe, 0);
    chk("abort_ready", ready, 1);
    chk("abort_addr", sram_addr, 0);
    chk("abort_dq_out", sram_dq_out, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_we_n", sram_we_n, 1);
      chk("post_rst_addr", sram_addr, 0);
      chk("post_rst_ready", ready, 1);
    end
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    // WAIT_CYCLES=1 load: ready low for exactly three cycles.
    @(negedge clk);
    rd1 = 1; addr1 = 32'd1036;
    #1 chk("w1_req_ready", ready1, 0);
    @(negedge clk);
    rd1 = 0; addr1 = 32'd0;
    chk("w1_lo_ready", ready1, 0);
    chk("w1_lo_addr", sram_addr1, 18'd6);
    @(negedge clk);
    chk("w1_hi_ready", ready1, 0);
    chk("w1_hi_addr", sram_addr1, 18'd7);
    chk("w1_we_n", we_n1, 1);
    @(negedge clk);
    chk("w1_done_ready", ready1, 1);
    chk("w1_rd_data", rd_data1, 32'h88887777);
    @(negedge clk);
    chk("w1_idle_ready", ready1, 1);
    chk("w1_idle_addr", sram_addr1, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
